// File: rtl/niosii_ram_pkg.sv
// Shared helpers for the dual-port on-chip RAM: lane count, read latency, collision lane merge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package niosii_ram_pkg;

    // Widest lane mask the collision helper handles (1024-bit words).
    localparam int MAX_LANES = 128;

    typedef logic [MAX_LANES-1:0] lane_mask_t;

    // Enabled edges from the edge that accepts a read to readdatavalid, without OUT_REG.
    localparam int RD_LAT_BASE = 1;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int rd_latency(input int out_reg);
        return RD_LAT_BASE + out_reg;
    endfunction

    // Lanes the second port may still write on a same-address collision:
    // the first port owns every lane it enables, the second fills the rest.
    function automatic lane_mask_t s2_lane_mask(input lane_mask_t be1,
                                                input lane_mask_t be2,
                                                input logic       collide);
        return collide ? (be2 & ~be1) : be2;
    endfunction

endpackage

// File: rtl/niosii_ram_rd_pipe.sv
// Read return pipeline for one port: turns an accepted read into a one-cycle readdatavalid.
// Latency: valid after the accepting edge (OUT_REG=0) or one enabled edge later (OUT_REG=1).
// Backpressure: none; every stage holds while en is low, reset empties the pipe.
module niosii_ram_rd_pipe
    import niosii_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] mem_dat,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid
);

    localparam int LAT = rd_latency(OUT_REG);

    logic vld1;

    // First valid stage tracks the memory read register one-for-one.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld1 <= 1'b0;
        end else if (en) begin
            vld1 <= issue;
        end
    end

    if (LAT == 1) begin : g_direct
        assign readdata      = mem_dat;
        assign readdatavalid = vld1;
    end else begin : g_out_reg
        logic                  vld2;
        logic [DATA_WIDTH-1:0] dat2;

        // Output register: data only loads on a returning read so it holds between reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld2 <= 1'b0;
                dat2 <= '0;
            end else if (en) begin
                vld2 <= vld1;
                if (vld1) begin
                    dat2 <= mem_dat;
                end
            end
        end

        assign readdata      = dat2;
        assign readdatavalid = vld2;
    end

endmodule

// File: rtl/niosii_onchip_ram_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves, byte-merged collisions and range check.
// Latency: read data and readdatavalid 1 enabled edge after acceptance, 2 with OUT_REG=1.
// Backpressure: none (no waitrequest); clken low or reset_req high freezes the whole block.
module niosii_onchip_ram_dp
    import niosii_ram_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 12,
    parameter int    DEPTH      = 4093,
    parameter int    OUT_REG    = 0,
    parameter string INIT_FILE  = "onchip_ram_dp.hex"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic                      reset_req,

    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,

    output logic                      oor_error
);

    localparam int                  LANES   = lane_count(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

    // Contents are preloaded from INIT_FILE by the device configuration flow.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic en;
    logic s1_in, s2_in;
    logic s1_acc, s2_acc;
    logic s1_wr, s2_wr;
    logic s1_rd, s2_rd;
    logic collide;
    logic [LANES-1:0] s2_be_eff;
    logic [DATA_WIDTH-1:0] s1_rdat, s2_rdat;

    assign en = clken & ~reset_req;

    assign s1_in = ({1'b0, s1_address} < DEPTH_L);
    assign s2_in = ({1'b0, s2_address} < DEPTH_L);

    assign s1_acc = s1_chipselect & (s1_read | s1_write) & en;
    assign s2_acc = s2_chipselect & (s2_read | s2_write) & en;

    // Write beats read on the same port; out-of-range writes never reach the array.
    assign s1_wr = s1_chipselect & s1_write & en & s1_in;
    assign s2_wr = s2_chipselect & s2_write & en & s2_in;
    assign s1_rd = s1_chipselect & s1_read & ~s1_write & en;
    assign s2_rd = s2_chipselect & s2_read & ~s2_write & en;

    assign collide   = s1_wr & s2_wr & (s1_address == s2_address);
    assign s2_be_eff = LANES'(s2_lane_mask(lane_mask_t'(s1_byteenable),
                                           lane_mask_t'(s2_byteenable),
                                           collide));

    // Byte-lane writes from both ports; a coinciding reset suppresses them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < LANES; b++) begin
                if (s1_wr && s1_byteenable[b]) begin
                    mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
                end
                if (s2_wr && s2_be_eff[b]) begin
                    mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read registers sample the pre-write contents; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_rdat <= '0;
            s2_rdat <= '0;
        end else begin
            if (s1_rd) begin
                s1_rdat <= s1_in ? mem[s1_address] : '0;
            end
            if (s2_rd) begin
                s2_rdat <= s2_in ? mem[s2_address] : '0;
            end
        end
    end

    // Sticky flag for any accepted access beyond the implemented depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            oor_error <= 1'b0;
        end else if ((s1_acc && !s1_in) || (s2_acc && !s2_in)) begin
            oor_error <= 1'b1;
        end
    end

    niosii_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_s1_pipe (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .issue         (s1_rd),
        .mem_dat       (s1_rdat),
        .readdata      (s1_readdata),
        .readdatavalid (s1_readdatavalid)
    );

    niosii_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_s2_pipe (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .issue         (s2_rd),
        .mem_dat       (s2_rdat),
        .readdata      (s2_readdata),
        .readdatavalid (s2_readdatavalid)
    );

endmodule

// File: tb/tb_niosii_onchip_ram_dp.sv
// Bench for the dual-port RAM: one instance per OUT_REG setting, shared stimulus,
// expected reads queued per port by a behavioural memory model, checked by a negedge monitor.
module tb_niosii_onchip_ram_dp;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4093;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clken, reset_req;
    logic [AW-1:0] addr [2];
    logic          cs   [2];
    logic          rd   [2];
    logic          wr   [2];
    logic [3:0]    be   [2];
    logic [DW-1:0] wd   [2];

    // Index 0/1: s1/s2 of the OUT_REG=0 instance, 2/3: s1/s2 of the OUT_REG=1 instance.
    logic [DW-1:0] rdat [4];
    logic          rvld [4];
    logic          oor  [2];

    niosii_onchip_ram_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(0), .INIT_FILE("onchip_ram_dp.hex")
    ) u_lat1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdat[0]), .s1_readdatavalid(rvld[0]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdat[1]), .s2_readdatavalid(rvld[1]),
        .oor_error(oor[0])
    );

    niosii_onchip_ram_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(1), .INIT_FILE("onchip_ram_dp.hex")
    ) u_lat2 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdat[2]), .s1_readdatavalid(rvld[2]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdat[3]), .s2_readdatavalid(rvld[3]),
        .oor_error(oor[1])
    );

    typedef struct {
        logic [DW-1:0] dat;
        int            due;
    } exp_t;

    exp_t          q [4][$];
    logic [DW-1:0] mem_m [0:4095];
    int            ecnt     = 0;
    bit            last_en  = 1'b0;
    bit            last_rst = 1'b0;
    bit            started  = 1'b0;
    bit            oor_m    = 1'b0;
    int            n_chk    = 0;
    int            n_fail   = 0;
    logic [DW-1:0] prev_dat [4];
    logic          prev_vld [4];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference behaviour of one clock edge: reset, enable, reads see old contents, s1 owns shared lanes.
    function automatic void model_edge();
        bit   en_m;
        exp_t e;
        en_m     = clken && !reset_req;
        last_rst = reset;
        last_en  = en_m && !reset;
        if (reset) begin
            started = 1'b1;
            oor_m   = 1'b0;
            for (int i = 0; i < 4; i++) q[i].delete();
            return;
        end
        if (!en_m) return;
        ecnt++;
        for (int p = 0; p < 2; p++) begin
            if (cs[p] && (rd[p] || wr[p]) && addr[p] >= DEPTH) oor_m = 1'b1;
            if (cs[p] && rd[p] && !wr[p]) begin
                e.dat = (addr[p] < DEPTH) ? mem_m[addr[p]] : '0;
                e.due = ecnt;
                q[p].push_back(e);
                e.due = ecnt + 1;
                q[2 + p].push_back(e);
            end
        end
        for (int p = 1; p >= 0; p--) begin
            if (cs[p] && wr[p] && addr[p] < DEPTH) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[p][b]) mem_m[addr[p]][b*8 +: 8] = wd[p][b*8 +: 8];
                end
            end
        end
    endfunction

    // Monitor: after each edge, compare every read port and the error flags against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 4; i++) begin
                if (last_rst) begin
                    check($sformatf("reset valid p%0d", i), {31'b0, rvld[i]}, 32'd0);
                    check($sformatf("reset data p%0d", i), rdat[i], 32'd0);
                end else if (last_en) begin
                    if (q[i].size() > 0 && q[i][0].due <= ecnt) begin
                        check($sformatf("valid p%0d", i), {31'b0, rvld[i]}, 32'd1);
                        if (rvld[i]) check($sformatf("read data p%0d", i), rdat[i], q[i][0].dat);
                        q[i].delete(0);
                    end else begin
                        check($sformatf("no valid p%0d", i), {31'b0, rvld[i]}, 32'd0);
                    end
                end else begin
                    check($sformatf("freeze valid p%0d", i), {31'b0, rvld[i]}, {31'b0, prev_vld[i]});
                    check($sformatf("freeze data p%0d", i), rdat[i], prev_dat[i]);
                end
                prev_vld[i] = rvld[i];
                prev_dat[i] = rdat[i];
            end
            for (int d = 0; d < 2; d++) begin
                check($sformatf("oor_error dut%0d", d), {31'b0, oor[d]}, {31'b0, oor_m});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        reset     = 1'b0;
        clken     = 1'b1;
        reset_req = 1'b0;
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0;
            rd[p] = 1'b0;
            wr[p] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rd_req(input int p, input int a);
        cs[p]   = 1'b1;
        rd[p]   = 1'b1;
        wr[p]   = 1'b0;
        addr[p] = AW'(a);
    endtask

    task automatic wr_req(input int p, input int a, input logic [DW-1:0] d, input logic [3:0] b);
        cs[p]   = 1'b1;
        rd[p]   = 1'b0;
        wr[p]   = 1'b1;
        addr[p] = AW'(a);
        wd[p]   = d;
        be[p]   = b;
    endtask

    initial begin
        reset     = 1'b1;
        clken     = 1'b1;
        reset_req = 1'b0;
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
            addr[p] = '0; be[p] = '0; wd[p] = '0;
        end
        tick();
        reset = 1'b1;
        tick();
        idle(2);

        // Known contents for the small address window used below.
        for (int a = 0; a < 32; a++) begin
            wr_req(0, a, 32'h0, 4'hF);
            tick();
        end

        // Plain write on s1, readback on s2.
        wr_req(0, 5, 32'hDEADBEEF, 4'hF);
        tick();
        rd_req(1, 5);
        tick();
        idle(3);

        // Same-address write collision merged per byte.
        wr_req(0, 7, 32'h11223344, 4'h3);
        wr_req(1, 7, 32'hAABBCCDD, 4'hE);
        tick();
        rd_req(1, 7);
        rd_req(0, 7);
        tick();
        idle(3);

        // Read-before-write across ports, then the new value.
        wr_req(0, 9, 32'h00000055, 4'hF);
        rd_req(1, 9);
        tick();
        rd_req(1, 9);
        tick();
        idle(3);

        // Last implemented word.
        wr_req(1, DEPTH - 1, 32'hCAFEF00D, 4'hF);
        tick();
        rd_req(0, DEPTH - 1);
        tick();
        idle(3);

        // Four-read burst with a three-cycle reset_req pause in the middle.
        for (int a = 10; a < 14; a++) begin
            wr_req(1, a, 32'hA5000000 + a, 4'hF);
            tick();
        end
        rd_req(1, 10); tick();
        rd_req(1, 11); tick();
        for (int k = 0; k < 3; k++) begin
            reset_req = 1'b1;
            rd_req(1, 12);
            tick();
        end
        rd_req(1, 12); tick();
        rd_req(1, 13); tick();
        idle(4);

        // Out-of-range read, dropped write, sticky flag.
        rd_req(1, DEPTH);
        tick();
        idle(2);
        wr_req(0, DEPTH, 32'h1, 4'hF);
        tick();
        rd_req(1, DEPTH);
        rd_req(0, DEPTH + 2);
        tick();
        idle(3);

        // Reset with reads in flight; memory survives, a write under reset is dropped.
        wr_req(0, 20, 32'h12345678, 4'hF);
        tick();
        rd_req(0, 20); tick();
        rd_req(0, 20); rd_req(1, 20); tick();
        reset = 1'b1;
        rd_req(0, 20);
        wr_req(1, 20, 32'hFFFFFFFF, 4'hF);
        tick();
        idle(2);
        rd_req(0, 20); rd_req(1, 20); tick();
        idle(3);

        // Randomised traffic, stalls and collisions over a small window plus out-of-range words.
        for (int n = 0; n < 400; n++) begin
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 14) == 0);
            for (int p = 0; p < 2; p++) begin
                int a;
                a = ($urandom_range(0, 15) == 0) ? DEPTH + int'($urandom_range(0, 2))
                                                 : int'($urandom_range(0, 31));
                cs[p]   = ($urandom_range(0, 3) != 0);
                rd[p]   = 1'($urandom_range(0, 1));
                wr[p]   = ($urandom_range(0, 2) == 0);
                addr[p] = AW'(a);
                be[p]   = 4'($urandom_range(0, 15));
                wd[p]   = $urandom;
            end
            tick();
        end
        idle(6);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("outstanding reads p%0d", i), 32'(q[i].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
